// File: rtl/seven_seg_pkg.sv
// Shared constants and sizing helpers for the seven-segment display driver.
// Segment patterns are active-high with bit0 = segment a.
package seven_seg_pkg;

  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Dark level of the segment bus for each pin polarity.
  localparam logic [6:0] SEG_OFF_AH = 7'h00;
  localparam logic [6:0] SEG_OFF_AL = 7'h7F;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Prescaler must hold 0..refresh_div-1.
  function automatic int counter_width(input int refresh_div);
    return clog2_min1(refresh_div);
  endfunction

  function automatic int index_width(input int num_digits);
    return clog2_min1(num_digits);
  endfunction

endpackage

// File: rtl/seg_rom.sv
// Hex digit to seven-segment decode ROM, active-high, bit0 = segment a.
module seg_rom
  import seven_seg_pkg::*;
(
  input  logic [3:0] addr_i,
  output logic [6:0] pattern_o
);

  assign pattern_o = SEG_PATTERNS[addr_i];

endmodule

// File: rtl/seven_segment_mux_driver.sv
// Time-multiplexed seven-segment driver: shadow register, scan prescaler,
// leading-zero blanking and a registered pin stage sharing one segment bus.
module seven_segment_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int ACTIVE_LOW  = 1,
  parameter int LZ_BLANK    = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic                                  load,
  input  logic [4*NUM_DIGITS-1:0]               value,
  input  logic [NUM_DIGITS-1:0]                 dp_in,
  output logic [6:0]                            seg,
  output logic                                  dp,
  output logic [NUM_DIGITS-1:0]                 an,
  output logic [index_width(NUM_DIGITS)-1:0]    digit_idx
);

  localparam int CNT_W = counter_width(REFRESH_DIV);
  localparam int IDX_W = index_width(NUM_DIGITS);

  localparam logic                  POL      = (ACTIVE_LOW != 0);
  localparam logic                  BLANK_EN = (LZ_BLANK != 0);
  localparam logic [6:0]            SEG_OFF  = POL ? SEG_OFF_AL : SEG_OFF_AH;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{POL}};
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [IDX_W-1:0]        didx_q, didx_d;

  logic [3:0]              nibble;
  logic [6:0]              pattern;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   blank_mask;

  // Shadow capture and scan counters.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    val_d = val_q;
    sdp_d = sdp_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (load) begin
      val_d = value;
      sdp_d = dp_in;
    end
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nibble = '0;
    cur_dp = 1'b0;
    onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble    = val_q[4*i +: 4];
        cur_dp    = sdp_q[i];
        onehot[i] = 1'b1;
      end
    end
  end

  // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run      = zero_run && (val_q[4*i +: 4] == 4'h0);
      blank_mask[i] = zero_run && BLANK_EN;
    end
  end

  assign cur_blank = |(blank_mask & onehot);

  seg_rom u_seg_rom (
    .addr_i    (nibble),
    .pattern_o (pattern)
  );

  always_comb begin
    seg_d  = SEG_OFF;
    dp_d   = POL;
    an_d   = AN_OFF;
    didx_d = idx_q;
    if (enable) begin
      seg_d = cur_blank ? SEG_OFF : (pattern ^ {7{POL}});
      dp_d  = cur_dp ^ POL;
      an_d  = onehot ^ AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    if (rst) begin
      // NOTE: the shadow value is plain flops and is reset so the display restarts from a known 0, not garbage.
      val_q  <= '0;
      sdp_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_OFF;
      dp_q   <= POL;
      an_q   <= AN_OFF;
      didx_q <= '0;
    end else begin
      val_q  <= val_d;
      sdp_q  <= sdp_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      didx_q <= didx_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign digit_idx = didx_q;

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// Bench for seven_segment_mux_driver: ROM sweep on a 1-digit active-high
// instance, scoreboard-checked scan behaviour on a 4-digit active-low one.
module tb_seven_segment_mux_driver;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] idx;
  } out4_t;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } rom_vec_t;

  localparam logic [3:0] SCAN_AN  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  localparam logic [6:0] SCAN_SEG [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, en4, ld4;
  logic [15:0] val4;
  logic [3:0]  dpi4;
  logic [6:0]  seg4;
  logic        dp4;
  logic [3:0]  an4;
  logic [1:0]  idx4;

  logic        rst1, en1, ld1;
  logic [3:0]  val1;
  logic        dpi1;
  logic [6:0]  seg1;
  logic        dp1;
  logic        an1;
  logic        idx1;

  seven_segment_mux_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1), .LZ_BLANK(1)
  ) u_dut4 (
    .clk(clk), .rst(rst4), .enable(en4), .load(ld4), .value(val4), .dp_in(dpi4),
    .seg(seg4), .dp(dp4), .an(an4), .digit_idx(idx4)
  );

  seven_segment_mux_driver #(
    .NUM_DIGITS(1), .REFRESH_DIV(2), .ACTIVE_LOW(0), .LZ_BLANK(0)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .load(ld1), .value(val1), .dp_in(dpi1),
    .seg(seg1), .dp(dp1), .an(an1), .digit_idx(idx1)
  );

  int          checks = 0;
  int          errors = 0;
  rom_vec_t    rom_tbl [16];
  out4_t       sb_q [$];
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected 4-digit pins after the coming edge, from pre-edge model state.
  function automatic out4_t model_out(input logic r, input logic e);
    out4_t       o;
    logic [15:0] upper;
    logic [3:0]  nib;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    o.an  = 4'hF;
    o.idx = r ? 2'd0 : 2'(m_idx);
    if (!r && e) begin
      upper = m_val >> (4 * m_idx);
      nib   = upper[3:0];
      o.seg = (m_idx != 0 && upper == 16'h0) ? 7'h7F : ~rom_tbl[nib].seg;
      o.dp  = ~m_dp[m_idx];
      o.an  = ~(4'b0001 << m_idx);
    end
    return o;
  endfunction

  task automatic cycle(input logic r, input logic e, input logic l,
                       input logic [15:0] v, input logic [3:0] d);
    out4_t exp_o;
    out4_t act_o;
    rst4 = r; en4 = e; ld4 = l; val4 = v; dpi4 = d;
    sb_q.push_back(model_out(r, e));
    if (r) begin
      m_val = '0; m_dp = '0; m_cnt = 0; m_idx = 0;
    end else begin
      if (l) begin
        m_val = v; m_dp = d;
      end
      if (e) begin
        if (m_cnt == 3) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % 4;
        end else begin
          m_cnt++;
        end
      end
    end
    @(negedge clk);
    exp_o = sb_q.pop_front();
    act_o = {seg4, dp4, an4, idx4};
    check("scoreboard", 32'(act_o), 32'(exp_o));
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int n;
    n = 0;
    do begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
      n++;
    end while (an4 !== target && n < 64);
    check(name, 32'(an4), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] pats [16];
    pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 16; i++) rom_tbl[i] = '{nib: 4'(i), seg: pats[i]};

    rst1 = 1'b1; en1 = 1'b0; ld1 = 1'b0; val1 = '0; dpi1 = 1'b0;
    rst4 = 1'b1; en4 = 1'b0; ld4 = 1'b0; val4 = '0; dpi4 = '0;

    // 1-digit, active-high instance: reset and ROM sweep.
    @(negedge clk);
    check("d1_rst_seg", 32'(seg1), 32'h0);
    check("d1_rst_dp",  32'(dp1),  32'h0);
    check("d1_rst_an",  32'(an1),  32'h0);
    rst1 = 1'b0; en1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ld1 = 1'b1; val1 = rom_tbl[i].nib; dpi1 = rom_tbl[i].nib[0];
      @(negedge clk);
      ld1 = 1'b0;
      repeat (9) @(negedge clk);
      check($sformatf("rom_seg_%h", rom_tbl[i].nib), 32'(seg1), 32'(rom_tbl[i].seg));
      check($sformatf("rom_dp_%h", rom_tbl[i].nib), 32'(dp1), 32'(rom_tbl[i].nib[0]));
      check($sformatf("rom_an_%h", rom_tbl[i].nib), 32'(an1), 32'h1);
      check($sformatf("rom_idx_%h", rom_tbl[i].nib), 32'(idx1), 32'h0);
    end

    // 4-digit, active-low instance: reset, with rst dominating load/enable.
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    check("rst_seg", 32'(seg4), 32'h7F);
    check("rst_dp",  32'(dp4),  32'h1);
    check("rst_an",  32'(an4),  32'hF);
    check("rst_idx", 32'(idx4), 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);

    // Scan order over two frames.
    cycle(1'b0, 1'b1, 1'b1, 16'h12AF, 4'h0);
    check("scan_load_seg", 32'(seg4), 32'h40);
    for (int k = 0; k < 8; k++) begin
      repeat (4) cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
      check($sformatf("scan_an_%0d", k),  32'(an4),  32'(SCAN_AN[(k + 1) % 4]));
      check($sformatf("scan_seg_%0d", k), 32'(seg4), 32'(SCAN_SEG[(k + 1) % 4]));
      check($sformatf("scan_idx_%0d", k), 32'(idx4), 32'((k + 1) % 4));
    end

    // Leading-zero blanking with a dp on a blanked digit.
    cycle(1'b0, 1'b1, 1'b1, 16'h0005, 4'b0100);
    wait_an(4'hB, "blank_reach_d2");
    check("blank_d2_seg", 32'(seg4), 32'h7F);
    check("blank_d2_dp",  32'(dp4),  32'h0);
    wait_an(4'h7, "blank_reach_d3");
    check("blank_d3_seg", 32'(seg4), 32'h7F);
    check("blank_d3_dp",  32'(dp4),  32'h1);
    wait_an(4'hD, "blank_reach_d1");
    check("blank_d1_seg", 32'(seg4), 32'h7F);
    wait_an(4'hE, "blank_reach_d0");
    check("blank_d0_seg", 32'(seg4), 32'h12);
    cycle(1'b0, 1'b1, 1'b1, 16'h0000, 4'h0);
    wait_an(4'hE, "zero_reach_d0");
    check("zero_d0_seg", 32'(seg4), 32'h40);
    wait_an(4'h7, "zero_reach_d3");
    check("zero_d3_seg", 32'(seg4), 32'h7F);

    // Load on the same edge as an index advance.
    for (int n = 0; n < 32 && !(m_idx == 0 && m_cnt == 3); n++)
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    cycle(1'b0, 1'b1, 1'b1, 16'h3456, 4'h0);
    check("adv_load_old_an",  32'(an4),  32'hE);
    check("adv_load_old_seg", 32'(seg4), 32'h40);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    check("adv_load_new_an",  32'(an4),  32'hD);
    check("adv_load_new_seg", 32'(seg4), 32'h12);

    // Disable at digit 2, load while dark, re-enable.
    for (int n = 0; n < 32 && m_idx != 2; n++)
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    check("dis_an",  32'(an4),  32'hF);
    check("dis_seg", 32'(seg4), 32'h7F);
    check("dis_dp",  32'(dp4),  32'h1);
    check("dis_idx", 32'(idx4), 32'h2);
    cycle(1'b0, 1'b0, 1'b1, 16'h8888, 4'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    check("dis_hold_idx", 32'(idx4), 32'h2);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    check("reen_an",  32'(an4),  32'hB);
    check("reen_seg", 32'(seg4), 32'h00);
    check("reen_idx", 32'(idx4), 32'h2);

    // Reset mid-scan at digit 3, prescaler 2, with load and enable also high.
    for (int n = 0; n < 32 && !(m_idx == 3 && m_cnt == 2); n++)
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    cycle(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF);
    check("mrst_idx", 32'(idx4), 32'h0);
    check("mrst_an",  32'(an4),  32'hF);
    check("mrst_seg", 32'(seg4), 32'h7F);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    check("mrst_restart_an",  32'(an4),  32'hE);
    check("mrst_restart_seg", 32'(seg4), 32'h40);
    repeat (12) cycle(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux_driver.md
Name: seven_segment_mux_driver

Overview:
Time-multiplexed driver for a bank of NUM_DIGITS common-anode/cathode seven-segment digits, sharing one segment bus. A hex value is latched into a shadow register, and each nibble is decoded through a 16-entry segment ROM. Anodes are scanned at a programmable refresh rate, with optional leading-zero blanking and per-digit decimal points. The block sits between the datapath (value source) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8
REFRESH_DIV, 1000, clock cycles each digit stays lit; legal minimum 2
ACTIVE_LOW, 1, 1 = seg/dp/an driven active-low; 0 = active-high
LZ_BLANK, 1, 1 = blank leading zero digits; digit 0 is never blanked

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  1 = scan running; 0 = display dark, counters hold
load  input  1  single-cycle strobe; captures value and dp_in
value  input  4*NUM_DIGITS  hex digits; nibble i is digit i; digit 0 is the LSB nibble
dp_in  input  NUM_DIGITS  decimal point request per digit
seg  output  7  segment bus {g,f,e,d,c,b,a}, registered
dp  output  1  decimal point of the current digit, registered
an  output  NUM_DIGITS  one-hot anode select, registered
digit_idx  output  clog2(NUM_DIGITS) (min 1)  index of the digit presently driven

Behaviour:
- Reset, on the next clk edge with rst=1:
  - shadow value = 0, shadow dp = 0.
  - Prescaler = 0, scan index = 0, digit_idx = 0.
  - seg, dp and an all at their OFF level: all 1 if ACTIVE_LOW, all 0 otherwise.
- rst dominates load and enable in the same cycle. Reset mid-scan restarts the scan at digit 0.
- Shadow registers: when load=1, capture value/dp_in at the edge. The display never shows a mix of old and new nibbles within one output cycle.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while enable=1.
  - At count REFRESH_DIV-1 it wraps to 0 and the scan index increments.
  - The scan index wraps from NUM_DIGITS-1 to 0.
  - Full frame period = NUM_DIGITS*REFRESH_DIV cycles.
- Output register: seg/dp/an/digit_idx at cycle n+1 reflect the scan index and shadow at cycle n. This gives 1-cycle latency after an index change or load.
- Decode ROM, active-high, bit0 = a: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- ACTIVE_LOW inverts seg, dp and an after decode.
- an is one-hot on the current index, e.g. idx 2 with ACTIVE_LOW gives an = 4'b1011.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit i>0 is blanked when its nibble and all higher nibbles are 0.
  - Blanked means seg OFF and dp still follows the shadow dp. The anode is still asserted, so scan timing is unchanged.
  - Value 0 displays a single "0" on digit 0.
- enable=0:
  - At the next edge, an goes all OFF and seg/dp go OFF.
  - Prescaler and index freeze.
  - Re-enable resumes from the frozen index and count.
  - load is still honoured.
- Simultaneous load and index advance: both take effect at the same edge. The next output cycle shows the new value at the new index.
- NUM_DIGITS=1: the index stays 0 and an is permanently asserted while enabled.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry segment pattern constant array;
  - OFF-level constants;
  - a function computing the counter width from REFRESH_DIV.
- One sub-module, seg_rom: combinational 4-bit address to 7-bit active-high pattern. It is the reusable hex decode ROM, instantiated once on the muxed nibble.
- Prescaler, index counter, blanking logic and output register live in the top module.

Test Plan:
- Reset: hold rst 3 cycles, ACTIVE_LOW=1, NUM_DIGITS=4 -> seg=7F, dp=1, an=4'hF, digit_idx=0 after the first edge.
- ROM sweep: NUM_DIGITS=1, ACTIVE_LOW=0, LZ_BLANK=0; load 0..F, 10 cycles each -> seg matches the table (0->3F, 8->7F, A->77, F->71).
- Scan order: REFRESH_DIV=4, load 16'h12AF, enable=1 -> every 4 cycles an walks E,D,B,7 (ACTIVE_LOW). seg = ~71, ~77, ~5B, ~06 in turn; the frame repeats every 16 cycles.
- Blanking: load 16'h0005 with dp_in=4'b0100 -> digits 3,1 seg OFF; digit 2 seg OFF but dp on; digit 0 shows ~6D. Load 0 -> only digit 0 shows ~3F.
- Enable/load timing: drop enable at idx 2 -> an OFF next cycle, idx stays 2. Load 16'h8888 while disabled, then re-enable -> digit 2 shows ~7F within 1 cycle.
- Mid-scan reset: assert rst at idx 3 with prescaler=2 -> next cycle idx=0, outputs OFF. Shadow=0, so after restart digit 0 shows ~3F.
